// File: rtl/aib_adapttxdp_pkg.sv
// Shared definitions for the TX adapter datapath FIFO read side.
//   - FIFO mode encodings (1:1, 2:1, 4:1, register mode)
//   - read-controller state encoding
//   - group_end(): tells whether the current word-select phase is the last
//     word of a read group for the given mode
package aib_adapttxdp_pkg;

  localparam logic [1:0] FIFO_1X = 2'b00;
  localparam logic [1:0] FIFO_2X = 2'b01;
  localparam logic [1:0] FIFO_4X = 2'b10;
  localparam logic [1:0] REG_MOD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } rd_state_e;

  // 2:1 groups end on odd phases, 4:1 groups end on phase 3, and in 1:1 or
  // register mode every word is its own group.
  function automatic logic group_end(input logic [1:0] mode, input logic [1:0] phase);
    case (mode)
      FIFO_2X: return phase[0];
      FIFO_4X: return (phase == 2'd3);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/aib_adapttxdp_fill_cnt.sv
// Saturating counter of consecutive cycles with the FIFO not partially empty.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   en       : count only while the controller is filling; cleared otherwise
//   pempty   : FIFO partially-empty flag; any high cycle restarts the count
//   thresh   : number of clean cycles to see before the fill is complete
//   done     : high in the cycle the count equals thresh with pempty low
module aib_adapttxdp_fill_cnt #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          pempty,
  input  logic [CW-1:0] thresh,
  output logic          done
);

  logic [CW-1:0] cnt;

  assign done = en & ~pempty & (cnt == thresh);

  // Count only uninterrupted runs; hold at all-ones instead of wrapping so a
  // long wait can never alias back to a small threshold.
  always_ff @(posedge clk) begin
    if (rst || !en || pempty) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/aib_adapttxdp_fifo_rd_ctrl.sv
// Read-side sequencer for the TX adapter async FIFO (read clock domain only).
// Waits for the FIFO to fill, then drives a continuous read enable that only
// ever stops on a word-group boundary, and records underflow/overflow errors.
// Ports:
//   rd_clk, rd_rst    : clock and synchronous active-high reset
//   r_rd_ena          : controller enable
//   r_fifo_mode       : 00=1:1, 01=2:1, 10=4:1, 11=register mode
//   r_fill_wait       : clean (non-pempty) cycles required before reading
//   r_auto_restart    : 1 = refill automatically after an error
//   err_clr           : clears the sticky error flags, releases ERR
//   rd_empty/pempty/full : FIFO read-domain status flags
//   rd_en, rd_valid   : read enable and its one-cycle delayed copy
//   rd_phase          : copy of the FIFO word-select counter
//   underflow_err, overflow_err : sticky error flags
//   state             : IDLE=0, FILL=1, RUN=2, ERR=3
module aib_adapttxdp_fifo_rd_ctrl
  import aib_adapttxdp_pkg::*;
#(
  parameter int FILL_CW = 4,
  parameter int MODE_W  = 2
) (
  input  logic               rd_clk,
  input  logic               rd_rst,
  input  logic               r_rd_ena,
  input  logic [MODE_W-1:0]  r_fifo_mode,
  input  logic [FILL_CW-1:0] r_fill_wait,
  input  logic               r_auto_restart,
  input  logic               err_clr,
  input  logic               rd_empty,
  input  logic               rd_pempty,
  input  logic               rd_full,
  output logic               rd_en,
  output logic               rd_valid,
  output logic [1:0]         rd_phase,
  output logic               underflow_err,
  output logic               overflow_err,
  output logic [1:0]         state
);

  rd_state_e state_q;
  logic      pend_err;
  logic      pend_idle;
  logic      fill_done;
  logic      uf_set;
  logic      of_set;
  logic      err_evt;
  logic      boundary;
  logic      to_idle;
  logic      stop_req;

  assign state = state_q;

  aib_adapttxdp_fill_cnt #(
    .CW(FILL_CW)
  ) u_fill_cnt (
    .clk    (rd_clk),
    .rst    (rd_rst),
    .en     (state_q == ST_FILL),
    .pempty (rd_pempty),
    .thresh (r_fill_wait),
    .done   (fill_done)
  );

  assign uf_set   = rd_en & rd_empty;
  assign of_set   = rd_full & (state_q != ST_IDLE);
  assign err_evt  = uf_set | of_set;
  assign boundary = group_end(r_fifo_mode[1:0], rd_phase);
  // A disable request, seen now or earlier in the group, wins over an error
  // when choosing where to go once the group completes.
  assign to_idle  = ~r_rd_ena | pend_idle;
  assign stop_req = err_evt | pend_err | to_idle;

  // Main sequencer. rd_phase advances on every read so it tracks the FIFO's
  // own word-select counter; rd_en is only ever released on a group boundary
  // so the two never fall out of group alignment. Pending-stop bits carry a
  // stop request from mid-group to the boundary cycle.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q       <= ST_IDLE;
      rd_en         <= 1'b0;
      rd_valid      <= 1'b0;
      rd_phase      <= 2'd0;
      underflow_err <= 1'b0;
      overflow_err  <= 1'b0;
      pend_err      <= 1'b0;
      pend_idle     <= 1'b0;
    end else begin
      rd_valid  <= rd_en;
      rd_en     <= 1'b0;
      pend_err  <= 1'b0;
      pend_idle <= 1'b0;

      if (rd_en) begin
        rd_phase <= rd_phase + 2'd1;
      end

      // A fresh error in the same cycle as err_clr keeps the flag set.
      if (uf_set) begin
        underflow_err <= 1'b1;
      end else if (err_clr) begin
        underflow_err <= 1'b0;
      end
      if (of_set) begin
        overflow_err <= 1'b1;
      end else if (err_clr) begin
        overflow_err <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (r_rd_ena) begin
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (of_set) begin
            state_q <= ST_ERR;
          end else if (!r_rd_ena) begin
            state_q <= ST_IDLE;
          end else if (fill_done) begin
            state_q <= ST_RUN;
            rd_en   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop_req && boundary) begin
            state_q <= to_idle ? ST_IDLE : ST_ERR;
          end else begin
            rd_en     <= 1'b1;
            pend_err  <= pend_err | err_evt;
            pend_idle <= pend_idle | ~r_rd_ena;
          end
        end
        ST_ERR: begin
          if (r_auto_restart) begin
            state_q <= ST_FILL;
          end else if (err_clr) begin
            state_q <= r_rd_ena ? ST_FILL : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
